// File: rtl/rgb_compositor.sv
// Layered sprite/background compositor with colour-key transparency, collision
// detect and a frame-timed damage-flash effect, on a two-stage pipeline.
module rgb_compositor #(
  parameter int                 NUM_LAYERS   = 4,
  parameter int                 COLOR_W      = 12,
  parameter logic [COLOR_W-1:0] BG_COLOR     = 12'hFDA,
  parameter logic [COLOR_W-1:0] KEY_COLOR    = 12'h000,
  parameter logic [COLOR_W-1:0] FLASH_COLOR  = 12'hFFF,
  parameter int                 BLINK_FRAMES = 4,
  parameter int                 FLASH_PHASES = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_pixel,
  input  logic [NUM_LAYERS-1:0]         layer_en,
  input  logic                          frame_tick,
  input  logic                          flash_start,
  output logic [COLOR_W-1:0]            RGB,
  output logic                          valid_out,
  output logic                          collide,
  output logic                          flashing
);

  localparam int TICK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int PHASE_W = (FLASH_PHASES > 1) ? $clog2(FLASH_PHASES) : 1;
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(BLINK_FRAMES - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(FLASH_PHASES - 1);

  typedef enum logic [1:0] {IDLE, FLASH_ON, FLASH_OFF} flash_state_t;

  flash_state_t        state, state_next;
  logic [TICK_W-1:0]   tick_cnt, tick_next;
  logic [PHASE_W-1:0]  phase_cnt, phase_next;

  logic [NUM_LAYERS-1:0] opaque;
  logic [COLOR_W-1:0]    sel_color;
  logic                  any_opaque;
  logic                  multi_opaque;

  logic [COLOR_W-1:0]    s1_color;
  logic                  s1_any;
  logic                  s1_multi;
  logic                  s1_valid;

  always_comb begin
    for (int i = 0; i < NUM_LAYERS; i++)
      opaque[i] = layer_en[i] && (layer_pixel[i*COLOR_W +: COLOR_W] != KEY_COLOR);
  end

  // Walk from the highest index down so the lowest opaque layer wins the colour.
  always_comb begin
    sel_color    = BG_COLOR;
    any_opaque   = 1'b0;
    multi_opaque = 1'b0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        if (any_opaque)
          multi_opaque = 1'b1;
        any_opaque = 1'b1;
        sel_color  = layer_pixel[i*COLOR_W +: COLOR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_color <= '0;
      s1_any   <= 1'b0;
      s1_multi <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      s1_color <= sel_color;
      s1_any   <= any_opaque;
      s1_multi <= multi_opaque;
      s1_valid <= valid;
    end
  end

  // The flash overrides only real sprite pixels, never the background.
  always_ff @(posedge clk) begin
    if (rst) begin
      RGB       <= '0;
      collide   <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= s1_valid;
      if (!s1_valid) begin
        RGB     <= '0;
        collide <= 1'b0;
      end else begin
        collide <= s1_multi;
        RGB     <= (state == FLASH_ON && s1_any) ? FLASH_COLOR : s1_color;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      phase_cnt <= '0;
    end else begin
      state     <= state_next;
      tick_cnt  <= tick_next;
      phase_cnt <= phase_next;
    end
  end

  // A new flash request restarts the sequence and swallows a coincident tick.
  always_comb begin
    state_next = state;
    tick_next  = tick_cnt;
    phase_next = phase_cnt;
    if (flash_start) begin
      state_next = FLASH_ON;
      tick_next  = '0;
      phase_next = '0;
    end else if (frame_tick && state != IDLE) begin
      if (tick_cnt == TICK_LAST) begin
        tick_next = '0;
        if (phase_cnt == PHASE_LAST) begin
          state_next = IDLE;
          phase_next = '0;
        end else begin
          state_next = (state == FLASH_ON) ? FLASH_OFF : FLASH_ON;
          phase_next = phase_cnt + 1'b1;
        end
      end else begin
        tick_next = tick_cnt + 1'b1;
      end
    end
  end

  assign flashing = (state != IDLE);

endmodule

// File: tb/tb_rgb_compositor.sv
// Directed, scoreboard-checked bench for rgb_compositor with default parameters.
module tb_rgb_compositor;

  typedef struct packed {
    logic [11:0] rgb;
    logic        col;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [47:0] layer_pixel;
  logic [3:0]  layer_en;
  logic        frame_tick;
  logic        flash_start;
  logic [11:0] RGB;
  logic        valid_out;
  logic        collide;
  logic        flashing;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   popped     = 0;

  // Layer 0 opaque red only; all layers key-coloured (background).
  localparam logic [47:0] OPQ_PIX = {12'h000, 12'h000, 12'h000, 12'hF00};
  localparam logic [47:0] BG_PIX  = 48'h0;

  rgb_compositor dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .layer_pixel(layer_pixel),
    .layer_en   (layer_en),
    .frame_tick (frame_tick),
    .flash_start(flash_start),
    .RGB        (RGB),
    .valid_out  (valid_out),
    .collide    (collide),
    .flashing   (flashing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point shared by the monitor and the direct checks.
  task automatic checkOutput(input string name, input logic [11:0] actual,
                             input logic [11:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs; a valid pixel queues its expected response.
  task automatic applyStimulus(input logic v, input logic [3:0] en,
                               input logic [47:0] pix, input logic fs,
                               input logic ft, input logic [11:0] exp_rgb,
                               input logic exp_col);
    exp_t e;
    valid       = v;
    layer_en    = en;
    layer_pixel = pix;
    flash_start = fs;
    frame_tick  = ft;
    if (v) begin
      e.rgb = exp_rgb;
      e.col = exp_col;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented output consumes the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_output: got RGB=%h with nothing pending", RGB);
      end else begin
        e = exp_q.pop_front();
        popped++;
        checkOutput($sformatf("rgb#%0d", popped), RGB, e.rgb);
        checkOutput($sformatf("collide#%0d", popped), 12'(collide), 12'(e.col));
      end
    end
  end

  initial begin
    logic on_phase;
    int   waited;

    // Reset state
    rst = 1'b1;
    valid = 1'b1; layer_en = 4'hF; layer_pixel = OPQ_PIX;
    frame_tick = 1'b0; flash_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rgb", RGB, 12'h000);
    checkOutput("reset_valid_out", 12'(valid_out), 12'h0);
    checkOutput("reset_collide", 12'(collide), 12'h0);
    checkOutput("reset_flashing", 12'(flashing), 12'h0);
    rst = 1'b0;

    // Priority and collision
    applyStimulus(1, 4'hF, {12'h00F, 12'h0F0, 12'h000, 12'h000}, 0, 0, 12'h0F0, 1);
    applyStimulus(1, 4'hF, {12'hABC, 12'h000, 12'h456, 12'h789}, 0, 0, 12'h789, 1);
    applyStimulus(1, 4'hF, {12'h123, 12'h000, 12'h000, 12'h000}, 0, 0, 12'h123, 0);

    // Background, then blanking
    applyStimulus(1, 4'hF, BG_PIX, 0, 0, 12'hFDA, 0);
    applyStimulus(1, 4'h0, {12'h111, 12'h222, 12'h333, 12'h444}, 0, 0, 12'hFDA, 0);
    applyStimulus(0, 4'hF, OPQ_PIX, 0, 0, 12'h000, 0);
    applyStimulus(0, 4'hF, OPQ_PIX, 0, 0, 12'h000, 0);
    checkOutput("blank_rgb", RGB, 12'h000);
    checkOutput("blank_valid_out", 12'(valid_out), 12'h0);
    checkOutput("blank_collide", 12'(collide), 12'h0);

    // Enable masking
    applyStimulus(1, 4'b0010, {12'h000, 12'h000, 12'h0F0, 12'hF00}, 0, 0, 12'h0F0, 0);
    applyStimulus(1, 4'b1110, {12'h00F, 12'h000, 12'h0F0, 12'hF00}, 0, 0, 12'h0F0, 1);

    // Full flash: 6 phases of 4 ticks, ON in phases 0, 2 and 4
    applyStimulus(1, 4'h1, OPQ_PIX, 1, 0, 12'hFFF, 0);
    checkOutput("flash_start_flashing", 12'(flashing), 12'h1);
    for (int k = 1; k <= 24; k++) begin
      on_phase = (k < 24) && (((k / 4) % 2) == 0);
      applyStimulus(1, 4'h1, OPQ_PIX, 0, 1, on_phase ? 12'hFFF : 12'hF00, 0);
      checkOutput($sformatf("flashing_tick%0d", k), 12'(flashing), (k < 24) ? 12'h1 : 12'h0);
      applyStimulus(1, 4'hF, BG_PIX, 0, 0, 12'hFDA, 0);
    end

    // Ticks while idle do nothing
    for (int k = 0; k < 3; k++)
      applyStimulus(1, 4'h1, OPQ_PIX, 0, 1, 12'hF00, 0);
    checkOutput("idle_tick_flashing", 12'(flashing), 12'h0);

    // Start + tick in the same cycle mid-flash restarts with counters at 0
    applyStimulus(0, 4'h0, BG_PIX, 1, 0, 12'h000, 0);
    for (int k = 0; k < 5; k++)
      applyStimulus(0, 4'h0, BG_PIX, 0, 1, 12'h000, 0);
    applyStimulus(1, 4'h1, OPQ_PIX, 1, 1, 12'hFFF, 0);
    applyStimulus(1, 4'h1, OPQ_PIX, 0, 1, 12'hFFF, 0);
    applyStimulus(1, 4'h1, OPQ_PIX, 0, 1, 12'hFFF, 0);
    applyStimulus(1, 4'h1, OPQ_PIX, 0, 1, 12'hFFF, 0);
    applyStimulus(1, 4'h1, OPQ_PIX, 0, 1, 12'hF00, 0);
    checkOutput("collision_flashing", 12'(flashing), 12'h1);

    // Reset during FLASH_ON aborts the flash and flushes the pipeline
    applyStimulus(1, 4'h1, OPQ_PIX, 1, 0, 12'hFFF, 0);
    applyStimulus(1, 4'h1, OPQ_PIX, 0, 0, 12'hFFF, 0);
    checkOutput("pre_reset_flashing", 12'(flashing), 12'h1);
    rst = 1'b1;
    frame_tick = 1'b0;
    flash_start = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    checkOutput("midreset_flashing", 12'(flashing), 12'h0);
    checkOutput("midreset_rgb", RGB, 12'h000);
    checkOutput("midreset_valid_out", 12'(valid_out), 12'h0);
    checkOutput("midreset_collide", 12'(collide), 12'h0);
    rst = 1'b0;
    applyStimulus(1, 4'h1, OPQ_PIX, 0, 0, 12'hF00, 0);
    applyStimulus(1, 4'hF, {12'h00F, 12'h0F0, 12'h000, 12'h000}, 0, 0, 12'h0F0, 1);
    applyStimulus(0, 4'h0, BG_PIX, 0, 0, 12'h000, 0);

    // Bounded drain of outstanding expectations
    waited = 0;
    while (exp_q.size() != 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: %0d outputs never appeared, expected 0 pending", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rgb_compositor.md
RGB_COMPOSITOR -- requirements
Module: rgb_compositor

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4, number of sprite/background layers (range 1..8).
REQ-002 SHALL have parameter COLOR_W, default 12, pixel width in 4:4:4 RGB.
REQ-003 SHALL have parameter BG_COLOR, default 12'hFDA, color shown where no layer is opaque.
REQ-004 SHALL have parameter KEY_COLOR, default 12'h000, transparency key.
REQ-005 SHALL have parameter FLASH_COLOR, default 12'hFFF, color substituted during a flash-on phase.
REQ-006 SHALL have parameter BLINK_FRAMES, default 4, frame ticks per flash phase (min 1).
REQ-007 SHALL have parameter FLASH_PHASES, default 6, total on+off phases per flash (min 1).
REQ-008 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-009 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-010 SHALL have port valid, input, 1, VGA active-area flag for the current pixel.
REQ-011 SHALL have port layer_pixel, input, NUM_LAYERS*COLOR_W, packed layer colors; layer i occupies bits [i*COLOR_W +: COLOR_W].
REQ-012 SHALL have port layer_en, input, NUM_LAYERS, per-layer enable; 0 means treat the layer as transparent.
REQ-013 SHALL have port frame_tick, input, 1, one-cycle pulse per frame (vsync edge).
REQ-014 SHALL have port flash_start, input, 1, one-cycle pulse that requests a damage flash.
REQ-015 SHALL have port RGB, output, COLOR_W, the composited pixel.
REQ-016 SHALL have port valid_out, output, 1, valid delayed to align with RGB.
REQ-017 SHALL have port collide, output, 1, set when 2 or more layers are opaque at this pixel.
REQ-018 SHALL have port flashing, output, 1, set while the flash FSM is not IDLE.

Function
REQ-019 SHALL treat layer i as opaque when layer_en[i]=1 and its pixel is not KEY_COLOR.
REQ-020 SHALL select the opaque layer with the lowest index (layer 0 has top priority); if no layer is opaque, SHALL select BG_COLOR.
REQ-021 SHALL register the stage-1 result (selected color, opaque count >= 2, valid) on every cycle.
REQ-022 SHALL form stage 2 from stage 1: when valid=0, RGB=0 and collide=0; when in FLASH_ON and at least one layer was opaque, RGB=FLASH_COLOR; otherwise RGB is the selected color.
REQ-023 SHALL register stage 2 into RGB, collide and valid_out, so the latency from the inputs is exactly 2 cycles.
REQ-024 SHALL sample the flash FSM state for stage 2 in the same cycle as the stage-1 data moves to stage 2.
REQ-025 SHALL implement the flash FSM with states IDLE, FLASH_ON and FLASH_OFF, plus a tick counter (0..BLINK_FRAMES-1) and a phase counter (0..FLASH_PHASES-1).
REQ-026 SHALL, on flash_start in any state, go to FLASH_ON on the next cycle with both counters cleared; a restart during a flash is allowed.
REQ-027 SHALL, on frame_tick in FLASH_ON or FLASH_OFF, increment the tick counter; when the tick counter is at BLINK_FRAMES-1, SHALL clear it and advance the phase.
REQ-028 SHALL, on a phase advance, alternate between FLASH_ON and FLASH_OFF and increment the phase counter; when the phase counter is at FLASH_PHASES-1, SHALL go to IDLE with both counters cleared.
REQ-029 SHALL give flash_start priority over frame_tick when both arrive in the same cycle: the tick is discarded and the counters start at 0.
REQ-030 SHALL ignore frame_tick in IDLE.
REQ-031 SHALL drive flashing combinationally from the registered FSM state, with no extra latency.

Reset
REQ-032 SHALL, while rst=1 at a clock edge, set RGB=0, valid_out=0, collide=0, the FSM to IDLE and both counters to 0, clear all pipeline registers, and make flashing=0.
REQ-033 SHALL, on reset during a flash, abort the flash immediately; the first output after reset has RGB=0 until valid data has passed through the 2-cycle pipeline.

Verification
REQ-034 SHALL have a directed test for priority: valid=1, en=4'b1111, layers {L3=12'h00F, L2=12'h0F0, L1=12'h000, L0=12'h000} -> two cycles later RGB=12'h0F0, collide=1.
REQ-035 SHALL have a directed test for background and blanking: all layers 12'h000 with valid=1 -> RGB=12'hFDA, collide=0; then valid=0 -> RGB=12'h000 two cycles later.
REQ-036 SHALL have a directed test for enable masking: L0=12'hF00 with en[0]=0, L1=12'h0F0 with en[1]=1 -> RGB=12'h0F0, collide=0.
REQ-037 SHALL have a directed test for the flash sequence: flash_start, then 24 frame_ticks (defaults) -> FSM goes ON/OFF/ON/OFF/ON/OFF with 4 ticks each and then IDLE; an opaque pixel shows 12'hFFF only in the ON phases; the background pixel never changes.
REQ-038 SHALL have a directed test for collision of start and tick: flash_start and frame_tick in the same cycle mid-flash -> FSM=FLASH_ON with both counters at 0.
REQ-039 SHALL have a directed test for mid-flash reset: rst pulsed during FLASH_ON -> next cycle flashing=0, RGB=0, valid_out=0; normal compositing resumes 2 cycles after rst is released.
